// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_pkg
//  Purpose  : Shared BE definitions: MMIO address map constants for the CLINT,
//             CLINT command/response bundles and the CLINT decode selector.
//  Revision : 1.0  initial CLINT MMIO support
// ============================================================================
package bp_be_pkg;

  // MMIO address map (39-bit virtual address space)
  localparam int unsigned vaddr_width_gp              = 39;
  localparam logic [38:0] clint_mtime_addr_gp         = 39'h6f_ffff_0000;
  localparam logic [38:0] clint_mtimecmp_base_addr_gp = 39'h6f_ffff_0100;
  localparam logic [38:0] clint_msoftint_base_addr_gp = 39'h6f_ffff_0200;

  // Per-hart register spacing and the number of harts the map reserves
  localparam int unsigned clint_stride_gp    = 8;
  localparam int unsigned clint_max_harts_gp = 8;

  typedef struct packed {
    logic                      w_v;
    logic [vaddr_width_gp-1:0] addr;
    logic [63:0]               data;
  } bp_be_clint_cmd_s;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } bp_be_clint_resp_s;

  typedef enum logic [1:0] {
    e_clint_sel_none  = 2'd0,
    e_clint_sel_mtime = 2'd1,
    e_clint_sel_cmp   = 2'd2,
    e_clint_sel_soft  = 2'd3
  } bp_be_clint_sel_e;

endpackage
`default_nettype wire

// File: rtl/bp_be_clint_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_clint_timer
//  Purpose  : Prescaler plus 64-bit mtime counter. mtime advances once every
//             timer_div_p cycles; a write loads mtime and restarts the
//             prescaler, overriding that cycle's increment.
//  Ports    : clk_i, reset_i (async, active high)
//             w_v_i / w_data_i : mtime write port
//             mtime_o          : current mtime register value
//  Revision : 1.0  initial release
// ============================================================================
module bp_be_clint_timer
  import bp_be_pkg::*;
#(
  parameter int timer_div_p = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        w_v_i,
  input  logic [63:0] w_data_i,
  output logic [63:0] mtime_o
);

  localparam int presc_width_lp = (timer_div_p > 1) ? $clog2(timer_div_p) : 1;
  localparam logic [presc_width_lp-1:0] presc_max_lp = presc_width_lp'(timer_div_p - 1);

  logic [presc_width_lp-1:0] presc_q, presc_d;
  logic [63:0]               mtime_q, mtime_d;
  logic                      tick;

  always_comb begin
    tick    = (presc_q == presc_max_lp);
    presc_d = tick ? '0 : presc_q + 1'b1;
    // Natural 64-bit overflow gives the 2^64-1 -> 0 wrap
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (w_v_i) begin
      presc_d = '0;
      mtime_d = w_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule
`default_nettype wire

// File: rtl/bp_be_clint_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_clint_mmio
//  Purpose  : Core-local interruptor. Decodes 64-bit MMIO loads/stores to
//             mtime, mtimecmp[hart] and msoftint[hart], returns one response
//             per command through a single-entry buffer, and drives per-hart
//             machine timer / software interrupt lines.
//  Ports    : clk_i, reset_i (async, active high)
//             cmd_v_i/cmd_ready_o/cmd_w_v_i/cmd_addr_i/cmd_data_i : command
//             resp_v_o/resp_ready_i/resp_data_o/resp_err_o        : response
//             timer_irq_o, soft_irq_o : per-hart interrupt outputs
//  Revision : 1.0  initial release
// ============================================================================
module bp_be_clint_mmio
  import bp_be_pkg::*;
#(
  parameter int num_core_p    = 8,
  parameter int vaddr_width_p = 39,
  parameter int timer_div_p   = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_w_v_i,
  input  logic [vaddr_width_p-1:0] cmd_addr_i,
  input  logic [63:0]              cmd_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_ready_i,
  output logic [63:0]              resp_data_o,
  output logic                     resp_err_o,
  output logic [num_core_p-1:0]    timer_irq_o,
  output logic [num_core_p-1:0]    soft_irq_o
);

  localparam int hart_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  logic                             accept;
  bp_be_clint_sel_e                 sel;
  logic [hart_width_lp-1:0]         hart;
  logic [63:0]                      rd_data;
  logic                             mtime_w_v;
  logic [63:0]                      mtime;

  logic [num_core_p-1:0][63:0]      mtimecmp_q, mtimecmp_d;
  logic [num_core_p-1:0]            msoftint_q, msoftint_d;
  logic [num_core_p-1:0]            timer_irq_q, timer_irq_d;
  logic                             resp_v_q, resp_v_d;
  bp_be_clint_resp_s                resp_q, resp_d;

  // The buffer can take a new command whenever it is empty or being drained
  assign cmd_ready_o = ~resp_v_q | resp_ready_i;
  assign accept      = cmd_v_i & cmd_ready_o;

  // Exact-match decode: misaligned addresses and harts beyond num_core_p
  // never match any entry and fall through as unmapped.
  always_comb begin
    sel  = e_clint_sel_none;
    hart = '0;
    if (cmd_addr_i == vaddr_width_p'(clint_mtime_addr_gp))
      sel = e_clint_sel_mtime;
    for (int i = 0; i < num_core_p; i++) begin
      if (cmd_addr_i == vaddr_width_p'(clint_mtimecmp_base_addr_gp)
                        + vaddr_width_p'(clint_stride_gp * i)) begin
        sel  = e_clint_sel_cmp;
        hart = hart_width_lp'(i);
      end
      if (cmd_addr_i == vaddr_width_p'(clint_msoftint_base_addr_gp)
                        + vaddr_width_p'(clint_stride_gp * i)) begin
        sel  = e_clint_sel_soft;
        hart = hart_width_lp'(i);
      end
    end
  end

  // Read mux uses register values before this cycle's update
  always_comb begin
    rd_data = '0;
    unique case (sel)
      e_clint_sel_mtime: rd_data = mtime;
      e_clint_sel_cmp:   rd_data = mtimecmp_q[hart];
      e_clint_sel_soft:  rd_data = {63'b0, msoftint_q[hart]};
      default:           rd_data = '0;
    endcase
  end

  // Register writes
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msoftint_d = msoftint_q;
    mtime_w_v  = accept & cmd_w_v_i & (sel == e_clint_sel_mtime);
    if (accept & cmd_w_v_i) begin
      if (sel == e_clint_sel_cmp)  mtimecmp_d[hart] = cmd_data_i;
      if (sel == e_clint_sel_soft) msoftint_d[hart] = cmd_data_i[0];
    end
  end

  // Timer interrupt is a registered compare of the current register values
  always_comb begin
    timer_irq_d = '0;
    for (int i = 0; i < num_core_p; i++)
      timer_irq_d[i] = (mtime >= mtimecmp_q[i]);
  end

  // Single-entry response buffer; an accept on a draining cycle reloads it
  always_comb begin
    resp_v_d = resp_v_q;
    resp_d   = resp_q;
    if (resp_ready_i)
      resp_v_d = 1'b0;
    if (accept) begin
      resp_v_d    = 1'b1;
      resp_d.data = cmd_w_v_i ? 64'd0 : rd_data;
      resp_d.err  = (sel == e_clint_sel_none);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mtimecmp_q  <= '1;
      msoftint_q  <= '0;
      timer_irq_q <= '0;
      resp_v_q    <= 1'b0;
      resp_q      <= '0;
    end else begin
      mtimecmp_q  <= mtimecmp_d;
      msoftint_q  <= msoftint_d;
      timer_irq_q <= timer_irq_d;
      resp_v_q    <= resp_v_d;
      resp_q      <= resp_d;
    end
  end

  bp_be_clint_timer #(
    .timer_div_p (timer_div_p)
  ) timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .w_v_i    (mtime_w_v),
    .w_data_i (cmd_data_i),
    .mtime_o  (mtime)
  );

  assign resp_v_o    = resp_v_q;
  assign resp_data_o = resp_q.data;
  assign resp_err_o  = resp_q.err;
  assign timer_irq_o = timer_irq_q;
  assign soft_irq_o  = msoftint_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_clint_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_be_clint_mmio
//  Purpose  : Self-checking bench for bp_be_clint_mmio. Stimulus pushes the
//             expected response into a queue; a monitor pops and compares on
//             every response handshake. Interrupt lines are checked directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_be_clint_mmio;
  import bp_be_pkg::*;

  localparam logic [38:0] a_mtime = 39'h6f_ffff_0000;
  localparam logic [38:0] a_cmp0  = 39'h6f_ffff_0100;
  localparam logic [38:0] a_cmp1  = 39'h6f_ffff_0108;
  localparam logic [38:0] a_cmp2  = 39'h6f_ffff_0110;
  localparam logic [38:0] a_soft1 = 39'h6f_ffff_0208;
  localparam logic [38:0] a_soft3 = 39'h6f_ffff_0218;
  localparam logic [38:0] a_soft5 = 39'h6f_ffff_0228;
  localparam logic [63:0] ones    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic        cmd_w_v_i;
  logic [38:0] cmd_addr_i;
  logic [63:0] cmd_data_i;
  logic        resp_v_o;
  logic        resp_ready_i;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic [7:0]  timer_irq_o;
  logic [7:0]  soft_irq_o;

  int checks = 0;
  int errors = 0;
  bp_be_clint_resp_s exp_q[$];

  bp_be_clint_mmio #(
    .num_core_p    (8),
    .vaddr_width_p (39),
    .timer_div_p   (1)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .cmd_v_i      (cmd_v_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_w_v_i    (cmd_w_v_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .resp_v_o     (resp_v_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .timer_irq_o  (timer_irq_o),
    .soft_irq_o   (soft_irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic w, input logic [38:0] addr, input logic [63:0] data,
                       input logic [63:0] exp_data, input logic exp_err);
    int n = 0;
    bp_be_clint_resp_s e;
    cmd_v_i    = 1'b1;
    cmd_w_v_i  = w;
    cmd_addr_i = addr;
    cmd_data_i = data;
    #1;
    while (!cmd_ready_o && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!cmd_ready_o) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready_o got 0 expected 1 for addr %h", addr);
    end else begin
      e.data = exp_data;
      e.err  = exp_err;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_v_i = 1'b0;
  endtask

  // Response monitor: compare on each handshake, away from the rising edge
  initial begin
    bp_be_clint_resp_s e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_i && resp_v_o && resp_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got data %h err %b expected no response", resp_data_o, resp_err_o);
        end else begin
          e = exp_q.pop_front();
          if (resp_data_o !== e.data || resp_err_o !== e.err) begin
            errors++;
            $display("FAIL resp: got data %h err %b expected data %h err %b",
                     resp_data_o, resp_err_o, e.data, e.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_i      = 1'b1;
    cmd_v_i      = 1'b0;
    cmd_w_v_i    = 1'b0;
    cmd_addr_i   = '0;
    cmd_data_i   = '0;
    resp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_resp_v",    64'(resp_v_o),    64'd0);
    chk("reset_resp_data", resp_data_o,      64'd0);
    chk("reset_resp_err",  64'(resp_err_o),  64'd0);
    chk("reset_timer_irq", 64'(timer_irq_o), 64'd0);
    chk("reset_soft_irq",  64'(soft_irq_o),  64'd0);
    reset_i = 1'b0;

    // Idle 10 ticks, then read mtime
    repeat (10) @(negedge clk);
    issue(1'b0, a_mtime, 64'd0, 64'd10, 1'b0);
    chk("idle_timer_irq", 64'(timer_irq_o), 64'd0);

    // mtimecmp[2]=20 written while mtime=5
    issue(1'b1, a_mtime, 64'd5,  64'd0, 1'b0);
    issue(1'b1, a_cmp2,  64'd20, 64'd0, 1'b0);
    repeat (14) @(negedge clk);
    chk("cmp2_before", 64'(timer_irq_o), 64'h00);
    @(negedge clk);
    chk("cmp2_rise",   64'(timer_irq_o), 64'h04);
    issue(1'b1, a_cmp2, ones, 64'd0, 1'b0);
    chk("cmp2_hold",   64'(timer_irq_o), 64'h04);
    @(negedge clk);
    chk("cmp2_fall",   64'(timer_irq_o), 64'h00);

    // Software interrupt: only bit 0 is stored
    issue(1'b1, a_soft3, 64'h3, 64'd0, 1'b0);
    chk("soft3_set",   64'(soft_irq_o), 64'h08);
    issue(1'b0, a_soft3, 64'd0, 64'h1, 1'b0);
    issue(1'b1, a_soft3, 64'd0, 64'd0, 1'b0);
    chk("soft3_clear", 64'(soft_irq_o), 64'h00);

    // mtime wrap, with hart 0 compare at 0
    issue(1'b1, a_cmp0,  64'd0, 64'd0, 1'b0);
    issue(1'b1, a_mtime, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0);
    chk("wrap_irq0_a", 64'(timer_irq_o[0]), 64'd1);
    issue(1'b0, a_mtime, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    chk("wrap_irq0_b", 64'(timer_irq_o[0]), 64'd1);
    issue(1'b0, a_mtime, 64'd0, ones, 1'b0);
    chk("wrap_irq0_c", 64'(timer_irq_o[0]), 64'd1);
    issue(1'b0, a_mtime, 64'd0, 64'd0, 1'b0);
    chk("wrap_irq0_d", 64'(timer_irq_o[0]), 64'd1);

    // Unmapped accesses: hart 8, misaligned, no state change
    issue(1'b0, 39'h6f_ffff_0140, 64'd0, 64'd0, 1'b1);
    issue(1'b0, 39'h6f_ffff_0104, 64'd0, 64'd0, 1'b1);
    issue(1'b1, 39'h6f_ffff_0204, 64'd1, 64'd0, 1'b1);
    chk("unmapped_soft", 64'(soft_irq_o), 64'h00);
    issue(1'b1, 39'h6f_ffff_010c, 64'd0, 64'd0, 1'b1);
    issue(1'b0, a_cmp1, 64'd0, ones, 1'b0);

    // Backpressure
    issue(1'b1, a_soft1, 64'h1, 64'd0, 1'b0);
    issue(1'b1, a_soft5, 64'h5, 64'd0, 1'b0);
    chk("soft_1_5", 64'(soft_irq_o), 64'h22);
    @(negedge clk);
    resp_ready_i = 1'b0;
    issue(1'b0, a_soft1, 64'd0, 64'h1, 1'b0);
    cmd_v_i    = 1'b1;
    cmd_w_v_i  = 1'b0;
    cmd_addr_i = a_cmp2;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ready",     64'(cmd_ready_o), 64'd0);
      chk("stall_resp_v",    64'(resp_v_o),    64'd1);
      chk("stall_resp_data", resp_data_o,      64'h1);
      @(negedge clk);
    end
    resp_ready_i = 1'b1;
    issue(1'b0, a_cmp2,  64'd0, ones,  1'b0);
    issue(1'b0, a_soft5, 64'd0, 64'h1, 1'b0);
    issue(1'b0, a_cmp0,  64'd0, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
